// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared widths, access-size and state types for the load/store unit
//
// Contents:
//   Word, RamAddress        data word and byte-address types
//   AccessSize              BYTE / HALF / WORD
//   LsuState                IDLE / ACCESS / MERGE
//   is_misaligned()         alignment rule for a size and the low address bits
package lsu_pkg;

    localparam int WORD_WIDTH        = 32;
    localparam int WORD_ADDRESS_SIZE = 8;                      // words in ram = 2**WORD_ADDRESS_SIZE
    localparam int RAM_ADDRESS_SIZE  = WORD_ADDRESS_SIZE + 2;  // byte address

    typedef logic [WORD_WIDTH-1:0]       Word;
    typedef logic [RAM_ADDRESS_SIZE-1:0] RamAddress;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } AccessSize;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE
    } LsuState;

    // Bytes are always aligned; halves need bit 0 clear; words need bits 1:0 clear.
    function automatic logic is_misaligned(input AccessSize size, input logic [1:0] low);
        case (size)
            SIZE_HALF: is_misaligned = low[0];
            SIZE_WORD: is_misaligned = |low;
            default:   is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_extract.sv
// rtl/lsu_lane_extract.sv - selects a byte/half lane of a ram word and extends it to a full word
//
// Ports:
//   word         in   Word        full ram word (little-endian lanes)
//   offset       in   [1:0]       low byte-address bits
//   size         in   AccessSize  BYTE/HALF/WORD
//   is_unsigned  in   1           zero-extend when 1, sign-extend when 0
//   result       out  Word        extended lane (WORD returns the word untouched)
module lane_extract
    import lsu_pkg::*;
(
    input  Word        word,
    input  logic [1:0] offset,
    input  AccessSize  size,
    input  logic       is_unsigned,
    output Word        result
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = word[{offset, 3'b000} +: 8];
        lane_half = word[{offset[1], 4'b0000} +: 16];
        result    = word;
        case (size)
            SIZE_BYTE: result = is_unsigned ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            SIZE_HALF: result = is_unsigned ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default:   result = word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - blocking load/store unit between the MEM stage and a word-organised ram
//
// Ports:
//   clk, reset                  clock (posedge), async active-high reset
//   req_valid/req_ready         request handshake; ready only in IDLE
//   req_write, req_size,
//   req_unsigned, req_address,
//   req_wdata                   request fields, latched on accept
//   resp_valid                  one-cycle completion pulse
//   resp_data                   load result (0 for stores and faults)
//   resp_misaligned             qualifies resp_valid; request was misaligned
//   ram_write_enable, ram_address, ram_in, ram_out
//                               word ram port: async read, sync write, word-aligned address
module lsu
    import lsu_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      req_valid,
    output logic      req_ready,
    input  logic      req_write,
    input  AccessSize req_size,
    input  logic      req_unsigned,
    input  RamAddress req_address,
    input  Word       req_wdata,
    output logic      resp_valid,
    output Word       resp_data,
    output logic      resp_misaligned,
    output logic      ram_write_enable,
    output RamAddress ram_address,
    output Word       ram_in,
    input  Word       ram_out
);

    LsuState   state;
    logic      write_q;
    AccessSize size_q;
    logic      unsigned_q;
    RamAddress addr_q;
    Word       wdata_q;
    Word       merged_q;

    Word       load_value;
    Word       merged_next;
    logic      misaligned;

    assign misaligned = is_misaligned(size_q, addr_q[1:0]);

    lane_extract u_lane_extract (
        .word        (ram_out),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .result      (load_value)
    );

    // Read-modify-write: the fetched word with only the addressed lane replaced.
    always_comb begin
        merged_next = ram_out;
        case (size_q)
            SIZE_BYTE: merged_next[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            SIZE_HALF: merged_next[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default:   merged_next = ram_out;
        endcase
    end

    // The ram port depends only on the latched request, so a new request
    // arriving on req_* can never disturb an access in flight.
    assign ram_address      = {addr_q[RAM_ADDRESS_SIZE-1:2], 2'b00};
    assign ram_in           = (state == MERGE) ? merged_q : wdata_q;
    assign ram_write_enable = (state == MERGE) ||
                              ((state == ACCESS) && write_q && (size_q == SIZE_WORD) && !misaligned);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_data       <= '0;
            resp_misaligned <= 1'b0;
            write_q         <= 1'b0;
            size_q          <= SIZE_BYTE;
            unsigned_q      <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            merged_q        <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_q     <= req_address;
                        wdata_q    <= req_wdata;
                        req_ready  <= 1'b0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (misaligned || !write_q || (size_q == SIZE_WORD)) begin
                        resp_valid      <= 1'b1;
                        resp_misaligned <= misaligned;
                        resp_data       <= (misaligned || write_q) ? '0 : load_value;
                        req_ready       <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        merged_q <= merged_next;
                        state    <= MERGE;
                    end
                end
                MERGE: begin
                    resp_valid      <= 1'b1;
                    resp_misaligned <= 1'b0;
                    resp_data       <= '0;
                    req_ready       <= 1'b1;
                    state           <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu with a behavioural word ram
module tb_lsu;
    import lsu_pkg::*;

    localparam int NWORDS = 1 << WORD_ADDRESS_SIZE;
    localparam int NBYTES = 1 << RAM_ADDRESS_SIZE;

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic      req_valid = 1'b0;
    logic      req_ready;
    logic      req_write = 1'b0;
    AccessSize req_size = SIZE_WORD;
    logic      req_unsigned = 1'b0;
    RamAddress req_address = '0;
    Word       req_wdata = '0;
    logic      resp_valid;
    Word       resp_data;
    logic      resp_misaligned;
    logic      ram_write_enable;
    RamAddress ram_address;
    Word       ram_in;
    Word       ram_out;

    always #5 clk = ~clk;

    lsu dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_address      (req_address),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_data        (resp_data),
        .resp_misaligned  (resp_misaligned),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_in           (ram_in),
        .ram_out          (ram_out)
    );

    // Word ram: async read, sync write. Writes are counted.
    Word  ram [0:NWORDS-1];
    logic clear_ram = 1'b1;
    int   wr_count = 0;
    assign ram_out = ram[ram_address[RAM_ADDRESS_SIZE-1:2]];
    always @(posedge clk) begin
        if (clear_ram) begin
            for (int i = 0; i < NWORDS; i++) ram[i] <= '0;
        end else if (ram_write_enable) begin
            ram[ram_address[RAM_ADDRESS_SIZE-1:2]] <= ram_in;
            wr_count <= wr_count + 1;
        end
    end

    // Reference model: plain byte-addressed memory.
    logic [7:0] model_mem [0:NBYTES-1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic void model_apply(input logic w, input AccessSize sz, input logic uns,
                                        input int a, input Word wd,
                                        output Word d, output logic mis, output int lat, output int wrs);
        int     n;
        longint v;
        n   = (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
        mis = (a % n) != 0;
        d   = '0;
        lat = 2;
        wrs = 0;
        if (mis) return;
        if (w) begin
            for (int i = 0; i < n; i++) model_mem[a + i] = wd[8*i +: 8];
            lat = (n == 4) ? 2 : 3;
            wrs = 1;
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (longint'(model_mem[a + i]) << (8 * i));
            if (!uns && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
            d = Word'(v);
        end
    endfunction

    // One request through the handshake; inputs are scrambled right after accept.
    task automatic do_req(input logic w, input AccessSize sz, input logic uns, input int a, input Word wd,
                          output Word d, output logic mis, output int lat, output int wrs,
                          output logic got, output logic single);
        int w0;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_address  = RamAddress'(a);
        req_wdata    = wd;
        req_valid    = 1'b1;
        w0 = wr_count;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_size     = AccessSize'($urandom_range(0, 2));
        req_unsigned = 1'($urandom);
        req_address  = RamAddress'($urandom);
        req_wdata    = $urandom;
        lat = 1;
        @(negedge clk);
        check("ram_address_aligned", 32'(ram_address), 32'(a & ~3));
        while (!resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        got = resp_valid;
        d   = resp_data;
        mis = resp_misaligned;
        wrs = wr_count - w0;
        @(negedge clk);
        single = !resp_valid;
    endtask

    typedef struct {
        logic      w;
        AccessSize sz;
        logic      uns;
        int        a;
        Word       wd;
        Word       exp_d;
        logic      exp_mis;
        int        exp_lat;
        int        exp_wr;
    } row_t;

    row_t rows[16];
    row_t b2b[4];

    initial begin
        Word  d, md;
        logic mis, mmis, got, single, acc;
        int   lat, mlat, wrs, mwrs, w0, pulses, idx, nresp;

        for (int i = 0; i < NBYTES; i++) model_mem[i] = '0;

        rows[0]  = '{1'b1, SIZE_WORD, 1'b0, 'h20, 32'hCAFEF00D, 32'h0,        1'b0, 2, 1};
        rows[1]  = '{1'b1, SIZE_WORD, 1'b0, 'h10, 32'h11223344, 32'h0,        1'b0, 2, 1};
        rows[2]  = '{1'b0, SIZE_WORD, 1'b0, 'h10, 32'h0,        32'h11223344, 1'b0, 2, 0};
        rows[3]  = '{1'b1, SIZE_BYTE, 1'b0, 'h11, 32'h00000080, 32'h0,        1'b0, 3, 1};
        rows[4]  = '{1'b0, SIZE_WORD, 1'b0, 'h10, 32'h0,        32'h11228044, 1'b0, 2, 0};
        rows[5]  = '{1'b0, SIZE_BYTE, 1'b0, 'h11, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0};
        rows[6]  = '{1'b0, SIZE_BYTE, 1'b1, 'h11, 32'h0,        32'h00000080, 1'b0, 2, 0};
        rows[7]  = '{1'b1, SIZE_HALF, 1'b0, 'h12, 32'h0000BEEF, 32'h0,        1'b0, 3, 1};
        rows[8]  = '{1'b0, SIZE_HALF, 1'b0, 'h12, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 0};
        rows[9]  = '{1'b0, SIZE_HALF, 1'b1, 'h12, 32'h0,        32'h0000BEEF, 1'b0, 2, 0};
        rows[10] = '{1'b0, SIZE_WORD, 1'b0, 'h10, 32'h0,        32'hBEEF8044, 1'b0, 2, 0};
        rows[11] = '{1'b0, SIZE_WORD, 1'b0, 'h13, 32'h0,        32'h0,        1'b1, 2, 0};
        rows[12] = '{1'b1, SIZE_HALF, 1'b0, 'h15, 32'h00001234, 32'h0,        1'b1, 2, 0};
        rows[13] = '{1'b0, SIZE_WORD, 1'b0, 'h14, 32'h0,        32'h0,        1'b0, 2, 0};
        rows[14] = '{1'b1, SIZE_BYTE, 1'b0, 'h13, 32'hFFFFFF7F, 32'h0,        1'b0, 3, 1};
        rows[15] = '{1'b0, SIZE_WORD, 1'b0, 'h10, 32'h0,        32'h7FEF8044, 1'b0, 2, 0};

        b2b[0] = '{1'b1, SIZE_WORD, 1'b0, 'h30, 32'h55667788, 32'h0,        1'b0, 2, 1};
        b2b[1] = '{1'b0, SIZE_BYTE, 1'b0, 'h31, 32'h0,        32'h00000077, 1'b0, 2, 0};
        b2b[2] = '{1'b1, SIZE_HALF, 1'b0, 'h32, 32'hFFFF9ABC, 32'h0,        1'b0, 3, 1};
        b2b[3] = '{1'b0, SIZE_WORD, 1'b0, 'h30, 32'h0,        32'h9ABC7788, 1'b0, 2, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_data", resp_data, 32'd0);
        check("reset_resp_misaligned", 32'(resp_misaligned), 32'd0);
        check("reset_ram_write_enable", 32'(ram_write_enable), 32'd0);
        clear_ram = 1'b0;
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            do_req(rows[i].w, rows[i].sz, rows[i].uns, rows[i].a, rows[i].wd, d, mis, lat, wrs, got, single);
            model_apply(rows[i].w, rows[i].sz, rows[i].uns, rows[i].a, rows[i].wd, md, mmis, mlat, mwrs);
            check($sformatf("row%0d_resp_seen", i), 32'(got), 32'd1);
            check($sformatf("row%0d_data", i), d, rows[i].exp_d);
            check($sformatf("row%0d_misaligned", i), 32'(mis), 32'(rows[i].exp_mis));
            check($sformatf("row%0d_latency", i), 32'(lat), 32'(rows[i].exp_lat));
            check($sformatf("row%0d_writes", i), 32'(wrs), 32'(rows[i].exp_wr));
            check($sformatf("row%0d_single_pulse", i), 32'(single), 32'd1);
        end

        // Reset while in MERGE of SB 0xAA@0x20: no write, no response
        @(negedge clk);
        req_write = 1'b1; req_size = SIZE_BYTE; req_unsigned = 1'b0;
        req_address = RamAddress'('h20); req_wdata = 32'h000000AA; req_valid = 1'b1;
        w0 = wr_count;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_merge_reached", 32'(ram_write_enable), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_merge_we", 32'(ram_write_enable), 32'd0);
        check("rst_merge_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check("rst_merge_no_resp", 32'(pulses), 32'd0);
        check("rst_merge_no_write", 32'(wr_count - w0), 32'd0);
        check("rst_merge_word", ram['h20 >> 2], 32'hCAFEF00D);
        check("rst_merge_ready_after", 32'(req_ready), 32'd1);

        // Back-to-back with req_valid held high
        idx = 0; nresp = 0;
        req_write = b2b[0].w; req_size = b2b[0].sz; req_unsigned = b2b[0].uns;
        req_address = RamAddress'(b2b[0].a); req_wdata = b2b[0].wd; req_valid = 1'b1;
        for (int c = 0; c < 40 && nresp < 4; c++) begin
            if (resp_valid) begin
                check($sformatf("b2b_data%0d", nresp), resp_data, b2b[nresp].exp_d);
                nresp++;
            end
            acc = req_valid && req_ready;
            if (acc && idx > 0) check($sformatf("b2b_accept_on_resp%0d", idx), 32'(resp_valid), 32'd1);
            @(posedge clk);
            #1;
            if (acc) begin
                model_apply(b2b[idx].w, b2b[idx].sz, b2b[idx].uns, b2b[idx].a, b2b[idx].wd, md, mmis, mlat, mwrs);
                idx++;
                if (idx < 4) begin
                    req_write = b2b[idx].w; req_size = b2b[idx].sz; req_unsigned = b2b[idx].uns;
                    req_address = RamAddress'(b2b[idx].a); req_wdata = b2b[idx].wd;
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_accepted", 32'(idx), 32'd4);
        check("b2b_responses", 32'(nresp), 32'd4);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check("b2b_no_extra_pulse", 32'(pulses), 32'd0);

        // Randomized against the byte model
        for (int i = 0; i < 150; i++) begin
            logic      rw, ru;
            AccessSize rs;
            int        ra;
            Word       rd;
            rw = 1'($urandom);
            ru = 1'($urandom);
            rs = AccessSize'($urandom_range(0, 2));
            ra = 'h40 + int'($urandom_range(0, 60));
            rd = $urandom;
            model_apply(rw, rs, ru, ra, rd, md, mmis, mlat, mwrs);
            do_req(rw, rs, ru, ra, rd, d, mis, lat, wrs, got, single);
            check($sformatf("rand%0d_resp_seen", i), 32'(got), 32'd1);
            check($sformatf("rand%0d_data", i), d, md);
            check($sformatf("rand%0d_misaligned", i), 32'(mis), 32'(mmis));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(mlat));
            check($sformatf("rand%0d_writes", i), 32'(wrs), 32'(mwrs));
        end

        // Full ram dump against the model
        for (int i = 0; i < NWORDS; i++) begin
            check($sformatf("ram_dump_word%0d", i), ram[i],
                  {model_mem[4*i + 3], model_mem[4*i + 2], model_mem[4*i + 1], model_mem[4*i]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
